// File: rtl/cpu_if_access_arbiter.sv
// cpu_if_access_arbiter: round-robin sharing of one CPU interface control FSM
// access port between NUM_REQ requesters.
//
// Each granted access is issued as a one-cycle read or write strobe. The
// arbiter then waits for cpu_ready to drop and rise again, and returns a
// one-cycle done pulse to the owner. All outputs are registered.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_req_read     per-requester read request (level, held until done)
//   i_req_write    per-requester write request (write wins over read)
//   o_req_gnt      one-hot owner of the access in flight, zero when idle
//   o_req_done     one-cycle completion pulse to the owner
//   o_grant_idx    binary index of the current or last owner
//   o_busy         high while an access is in flight
//   o_cpu_read     one-cycle read strobe to the control FSM
//   o_cpu_write    one-cycle write strobe to the control FSM
//   i_cpu_ready    access_ready from the control FSM
//   o_timeout_err  one-cycle watchdog pulse (constant 0 without the watchdog)
//
// Build option: define CPU_IF_ARB_TIMEOUT_EN to add a 16-bit watchdog that
// aborts an access stalled for TIMEOUT_CYCLES cycles.
module cpu_if_access_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDXW           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req_read,
    input  logic [NUM_REQ-1:0] i_req_write,
    output logic [NUM_REQ-1:0] o_req_gnt,
    output logic [NUM_REQ-1:0] o_req_done,
    output logic [IDXW-1:0]    o_grant_idx,
    output logic               o_busy,
    output logic               o_cpu_read,
    output logic               o_cpu_write,
    input  logic               i_cpu_ready,
    output logic               o_timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("cpu_if_access_arbiter: parameter out of range");
    end

    state_t             r_state, w_state_n;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_n;
    logic [NUM_REQ-1:0] r_done, w_done_n;
    logic [IDXW-1:0]    r_idx, w_idx_n;
    logic [IDXW-1:0]    r_ptr, w_ptr_n;
    logic               r_busy, w_busy_n;
    logic               r_rd, w_rd_n;
    logic               r_wr, w_wr_n;
    logic               r_tout, w_tout_n;

    logic [NUM_REQ-1:0] w_elig;
    logic [IDXW-1:0]    w_win;
    logic               w_found;

    // A requester whose done pulse is on this cycle has not yet had the
    // chance to drop its request, so it is masked to avoid a double grant.
    assign w_elig = (i_req_read | i_req_write) & ~r_done;

    // First eligible index after the pointer, searching upward with wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && w_elig[IDXW'(j)]) begin
                w_found = 1'b1;
                w_win   = IDXW'(j);
            end
        end
    end

`ifdef CPU_IF_ARB_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        w_expired;

    // Counter sits at zero in IDLE, so it is zero on entry to WAIT_ACK and
    // reaches TIMEOUT_CYCLES on the TIMEOUT_CYCLES-th edge after entry.
    assign w_expired = (r_state == WAIT_ACK || r_state == WAIT_DONE) &&
                       (r_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else          r_cnt <= (r_state == WAIT_ACK || r_state == WAIT_DONE) ? r_cnt + 16'd1 : 16'd0;
    end
`else
    logic w_expired;
    assign w_expired = 1'b0;
`endif

    always_comb begin
        w_state_n = r_state;
        w_gnt_n   = r_gnt;
        w_done_n  = '0;
        w_idx_n   = r_idx;
        w_ptr_n   = r_ptr;
        w_busy_n  = r_busy;
        w_rd_n    = 1'b0;
        w_wr_n    = 1'b0;
        w_tout_n  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found && i_cpu_ready) begin
                    w_state_n = WAIT_ACK;
                    w_gnt_n   = NUM_REQ'(1) << w_win;
                    w_idx_n   = w_win;
                    w_busy_n  = 1'b1;
                    w_wr_n    = i_req_write[w_win];
                    w_rd_n    = ~i_req_write[w_win];
                end
            end
            WAIT_ACK: begin
                if (!i_cpu_ready) w_state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_cpu_ready) begin
                    w_state_n = IDLE;
                    w_done_n  = r_gnt;
                    w_gnt_n   = '0;
                    w_busy_n  = 1'b0;
                    w_ptr_n   = r_idx;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_gnt_n   = '0;
                w_idx_n   = '0;
                w_busy_n  = 1'b0;
            end
        endcase
        // Watchdog abort: the owner still gets its done pulse so it can
        // release its request.
        if (w_expired) begin
            w_state_n = IDLE;
            w_done_n  = r_gnt;
            w_gnt_n   = '0;
            w_busy_n  = 1'b0;
            w_ptr_n   = r_idx;
            w_tout_n  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_idx   <= '0;
            r_ptr   <= IDXW'(NUM_REQ - 1);
            r_busy  <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_tout  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_gnt   <= w_gnt_n;
            r_done  <= w_done_n;
            r_idx   <= w_idx_n;
            r_ptr   <= w_ptr_n;
            r_busy  <= w_busy_n;
            r_rd    <= w_rd_n;
            r_wr    <= w_wr_n;
            r_tout  <= w_tout_n;
        end
    end

    assign o_req_gnt     = r_gnt;
    assign o_req_done    = r_done;
    assign o_grant_idx   = r_idx;
    assign o_busy        = r_busy;
    assign o_cpu_read    = r_rd;
    assign o_cpu_write   = r_wr;
    assign o_timeout_err = r_tout;

endmodule

// File: tb/tb_cpu_if_access_arbiter.sv
// tb_cpu_if_access_arbiter: directed self-checking bench for cpu_if_access_arbiter.
module tb_cpu_if_access_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_read;
    logic [3:0] req_write;
    logic [3:0] req_gnt;
    logic [3:0] req_done;
    logic [1:0] grant_idx;
    logic       busy;
    logic       cpu_read;
    logic       cpu_write;
    logic       cpu_ready;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;

    cpu_if_access_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_read   (req_read),
        .i_req_write  (req_write),
        .o_req_gnt    (req_gnt),
        .o_req_done   (req_done),
        .o_grant_idx  (grant_idx),
        .o_busy       (busy),
        .o_cpu_read   (cpu_read),
        .o_cpu_write  (cpu_write),
        .i_cpu_ready  (cpu_ready),
        .o_timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the request pattern set and cpu_ready=1.
    // Expects a grant on the next edge, runs the ready handshake, and
    // returns at the negedge where the done pulse is visible.
    task automatic run_access(input string tag, input int exp_idx, input bit exp_wr);
        @(negedge clk);
        chk({tag, "_gnt"}, 32'(req_gnt), 32'(1) << exp_idx);
        chk({tag, "_idx"}, 32'(grant_idx), 32'(exp_idx));
        chk({tag, "_wr"}, 32'(cpu_write), 32'(exp_wr));
        chk({tag, "_rd"}, 32'(cpu_read), 32'(!exp_wr));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        cpu_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_strobe_off"}, 32'({cpu_read, cpu_write}), 32'd0);
        @(negedge clk);
        chk({tag, "_nodone"}, 32'(req_done), 32'd0);
        cpu_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_done"}, 32'(req_done), 32'(1) << exp_idx);
        chk({tag, "_gnt_clr"}, 32'(req_gnt), 32'd0);
        chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_read  = '0;
        req_write = '0;
        cpu_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(req_gnt), 32'd0);
        chk("rst_done", 32'(req_done), 32'd0);
        chk("rst_idx", 32'(grant_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobe", 32'({cpu_read, cpu_write}), 32'd0);
        chk("rst_tout", 32'(timeout_err), 32'd0);

        // Single read from requester 2, ready drops 1 cycle and returns 3 later.
        rst_n    = 1'b1;
        req_read = 4'b0100;
        @(negedge clk);
        chk("rd_gnt", 32'(req_gnt), 32'h4);
        chk("rd_idx", 32'(grant_idx), 32'd2);
        chk("rd_strobe", 32'({cpu_read, cpu_write}), 32'b10);
        cpu_ready = 1'b0;
        @(negedge clk);
        chk("rd_strobe_1cyc", 32'(cpu_read), 32'd0);
        chk("rd_busy", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("rd_wait_gnt", 32'(req_gnt), 32'h4);
        cpu_ready = 1'b1;
        @(negedge clk);
        chk("rd_done", 32'(req_done), 32'h4);
        chk("rd_busy_clr", 32'(busy), 32'd0);
        req_read = '0;
        @(negedge clk);
        chk("rd_done_1cyc", 32'(req_done), 32'd0);
        chk("rd_idx_hold", 32'(grant_idx), 32'd2);

        // Reset in the middle of an access, asserted away from any edge.
        req_read = 4'b0010;
        @(negedge clk);
        chk("mid_gnt", 32'(req_gnt), 32'h2);
        cpu_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(req_gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_strobe", 32'({cpu_read, cpu_write}), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        cpu_ready = 1'b1;
        req_read  = '0;
        req_write = 4'b1111;

        // Round robin from a fresh pointer: 0,1,2,3,0, writes only.
        run_access("rr0", 0, 1'b1);
        run_access("rr1", 1, 1'b1);
        run_access("rr2", 2, 1'b1);
        run_access("rr3", 3, 1'b1);
        run_access("rr4", 0, 1'b1);
        req_write = '0;
        @(negedge clk);

        // Requester 1 with read and write: write wins; held request is masked
        // during its done cycle.
        req_read  = 4'b0010;
        req_write = 4'b0010;
        run_access("rw", 1, 1'b1);
        @(negedge clk);
        chk("mask_gnt", 32'(req_gnt), 32'd0);
        chk("mask_busy", 32'(busy), 32'd0);
        chk("mask_idx_hold", 32'(grant_idx), 32'd1);
        req_read  = '0;
        req_write = '0;
        @(negedge clk);

        // Ready held low blocks the grant.
        cpu_ready = 1'b0;
        req_read  = 4'b1000;
        @(negedge clk);
        chk("rdy_low_gnt0", 32'(req_gnt), 32'd0);
        @(negedge clk);
        chk("rdy_low_gnt1", 32'(req_gnt), 32'd0);
        chk("rdy_low_busy", 32'(busy), 32'd0);
        cpu_ready = 1'b1;
        run_access("rdy", 3, 1'b0);
        req_read = '0;
        @(negedge clk);

        // Stalled access: ready never returns.
        req_read = 4'b0001;
        @(negedge clk);
        chk("to_gnt", 32'(req_gnt), 32'h1);
        cpu_ready = 1'b0;
        repeat (7) @(negedge clk);
        chk("to_early", 32'(timeout_err), 32'd0);
        chk("to_busy", 32'(busy), 32'd1);
        @(negedge clk);
`ifdef CPU_IF_ARB_TIMEOUT_EN
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_done", 32'(req_done), 32'h1);
        chk("to_gnt_clr", 32'(req_gnt), 32'd0);
        chk("to_busy_clr", 32'(busy), 32'd0);
        req_read = '0;
        @(negedge clk);
        chk("to_err_1cyc", 32'(timeout_err), 32'd0);
        chk("to_done_1cyc", 32'(req_done), 32'd0);
        cpu_ready = 1'b1;
`else
        chk("to_none", 32'(timeout_err), 32'd0);
        chk("to_still_busy", 32'(busy), 32'd1);
        cpu_ready = 1'b1;
        @(negedge clk);
        chk("to_late_done", 32'(req_done), 32'h1);
        req_read = '0;
`endif
        @(negedge clk);
        chk("end_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_if_access_arbiter.md
Name: cpu_if_access_arbiter

Overview:
Shares one cpu_if_control_fsm access port between NUM_REQ requesters using round-robin arbitration. Sequences each granted access as a one-cycle read/write strobe and tracks the downstream access_ready handshake to completion. Returns a one-cycle per-requester done pulse. Sits between the bus-side requesters and the CPU interface control FSM.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
IDXW, $clog2(NUM_REQ), width of the grant index (derived; not to be overridden).
TIMEOUT_CYCLES, 255, watchdog limit in cycles for a stalled access; used only with the optional feature; range 1..65535.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset; asserted when 0.
req_read  in  NUM_REQ  per-requester read request, level; held until req_done.
req_write  in  NUM_REQ  per-requester write request, level; write wins over read when both set on the same requester.
req_gnt  out  NUM_REQ  one-hot owner of the current access; all-zero when idle.
req_done  out  NUM_REQ  one-cycle completion pulse to the owner.
grant_idx  out  IDXW  binary index of the current or last owner.
busy  out  1  high while an access is in flight.
cpu_read  out  1  one-cycle read strobe to the control FSM.
cpu_write  out  1  one-cycle write strobe to the control FSM.
cpu_ready  in  1  access_ready from the control FSM.
timeout_err  out  1  one-cycle watchdog pulse; tied 0 when the feature is absent.

Behaviour:
- Outputs are registered. Reset (reset=0) takes effect immediately and asynchronously:
  - req_gnt=0, req_done=0, grant_idx=0, busy=0, cpu_read=0, cpu_write=0, timeout_err=0.
  - state=IDLE; round-robin pointer=NUM_REQ-1, so requester 0 has first priority.
- Eligible requester: (req_read|req_write) is set and its req_done is not high in the current cycle. This masking prevents a double grant before the requester drops its request.
- State IDLE:
  - Transition when any requester is eligible and cpu_ready=1.
  - Winner is the first eligible index after the pointer, searching upward with wrap-around.
  - On that edge: req_gnt<=onehot(winner), grant_idx<=winner, busy<=1.
  - If req_write[winner]=1 then cpu_write<=1, else cpu_read<=1.
  - Next state is WAIT_ACK.
  - While cpu_ready=0 in IDLE, no grant is issued.
- State WAIT_ACK:
  - cpu_read and cpu_write return to 0 (strobe width is exactly one cycle).
  - When cpu_ready=0, go to WAIT_DONE.
- State WAIT_DONE:
  - When cpu_ready=1: req_done<=req_gnt, req_gnt<=0, busy<=0, pointer<=grant_idx, go to IDLE.
- Latency: a request sampled at edge 0 produces gnt and the strobe at edge 1. Completion produces done one edge after cpu_ready rises. The minimum gap between strobes is 1 IDLE cycle.
- Request changes:
  - A request dropped before it is granted is simply not granted.
  - A request dropped or changed while granted is ignored; the access runs to completion and done still pulses.
  - Request lines of non-owners are don't-care until IDLE.
- Unreachable state encodings return to IDLE with all outputs cleared.
- grant_idx holds its value after done; the pointer advances only on completion.

Optional Feature:
Macro CPU_IF_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT_ACK and increments each cycle in WAIT_ACK and WAIT_DONE.
  - When the counter reaches TIMEOUT_CYCLES, the arbiter pulses timeout_err and req_done for the owner for one cycle.
  - It also clears req_gnt and busy, advances the pointer, and returns to IDLE.
- Not defined: no counter is built; timeout_err is constant 0; WAIT states wait indefinitely.

Test Plan:
1. Reset mid-access: reset=0 while in WAIT_DONE -> same cycle, req_gnt=0, busy=0, cpu_read=cpu_write=0. After release, req_read=4'b0001 is granted to requester 0 first.
2. Single read: req_read=4'b0100 with cpu_ready=1 -> next edge req_gnt=4'b0100, grant_idx=2, cpu_read=1 for 1 cycle. Model drops ready 1 cycle later and raises it 3 cycles later -> req_done=4'b0100 for 1 cycle, busy=0.
3. Round-robin: all four req_write held high with each access completing -> grant order 0,1,2,3,0; cpu_write pulses once per grant and cpu_read is never asserted.
4. Read/write priority and done masking: requester 1 holds read=1 and write=1 -> cpu_write=1, cpu_read=0. Requester 1 holds its request for one cycle after done with no others pending -> no second grant that cycle.
5. Ready held low: cpu_ready=0 with req_read=4'b1000 -> no grant. Raising cpu_ready -> grant to requester 3 on the next edge.
6. With CPU_IF_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: model never re-raises ready -> timeout_err=1 and req_done owner bit=1, both for 1 cycle, 8 cycles after WAIT_ACK entry; arbiter returns to IDLE.
